// File: rtl/virtual_button_gen_if.sv
// Command port of virtual_button_gen: one request/response channel plus completion status.
// Handshake: a command transfers on a rising SlowClock edge where CmdValid and CmdReady are both high.
// CmdValid is ignored in every other cycle, and commands are never queued.
interface virtual_button_gen_if;
  logic       CmdValid;
  logic [1:0] CmdCode;
  logic       CmdReady;
  logic       Busy;
  logic       Done;
  logic [1:0] Status;

  modport master (
    output CmdValid, CmdCode,
    input  CmdReady, Busy, Done, Status
  );

  modport slave (
    input  CmdValid, CmdCode,
    output CmdReady, Busy, Done, Status
  );
endinterface

// File: rtl/virtual_button_gen.sv
// Timed active-low virtual power/reset button presses, requested over a command port.
// Presses yield to the physical buttons and are followed by a fixed lockout gap.
module virtual_button_gen #(
  parameter int unsigned SHORT_TICKS = 13,
  parameter int unsigned LONG_TICKS  = 40,
  parameter int unsigned RST_TICKS   = 7,
  parameter int unsigned GAP_TICKS   = 8
) (
  input  logic                       SlowClock,
  input  logic                       MainReset,
  input  logic                       Strobe16ms,
  input  logic                       Strobe125ms,
  input  logic                       PhysPwrBtn_N,
  input  logic                       PhysRstBtn_N,
  output logic                       VirtPwrBtn_N,
  output logic                       VirtRstBtn_N,
  output logic [1:0]                 state_dbg,
  virtual_button_gen_if.slave        cmd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SHORT_LOAD = SHORT_TICKS[7:0];
  localparam logic [7:0] LONG_LOAD  = LONG_TICKS[7:0];
  localparam logic [7:0] RST_LOAD   = RST_TICKS[7:0];
  localparam logic [7:0] GAP_LOAD   = GAP_TICKS[7:0];

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_INVALID = 2'b10;

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic       slow_tick, slow_tick_next;
  logic       rst_sel, rst_sel_next;
  logic [1:0] status_pend, status_pend_next;
  logic [1:0] status_q;

  logic pwr_meta, pwr_sync, rst_meta, rst_sync;
  logic phys_any;
  logic accept;
  logic press_tick;

  // Synchronizers flush high so an idle panel reads as released right out of reset.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      pwr_meta <= 1'b1;
      pwr_sync <= 1'b1;
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      pwr_meta <= PhysPwrBtn_N;
      pwr_sync <= pwr_meta;
      rst_meta <= PhysRstBtn_N;
      rst_sync <= rst_meta;
    end
  end

  assign phys_any     = !pwr_sync || !rst_sync;
  assign cmd.CmdReady = (state == S_IDLE) && !phys_any;
  assign accept       = cmd.CmdValid && cmd.CmdReady;
  assign press_tick   = slow_tick ? Strobe125ms : Strobe16ms;

  always_comb begin
    state_next       = state;
    count_next       = count;
    slow_tick_next   = slow_tick;
    rst_sel_next     = rst_sel;
    status_pend_next = status_pend;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd.CmdCode)
            2'b01: begin
              count_next     = SHORT_LOAD;
              slow_tick_next = 1'b0;
              rst_sel_next   = 1'b0;
              state_next     = S_PRESS;
            end
            2'b10: begin
              count_next     = LONG_LOAD;
              slow_tick_next = 1'b1;
              rst_sel_next   = 1'b0;
              state_next     = S_PRESS;
            end
            2'b11: begin
              count_next     = RST_LOAD;
              slow_tick_next = 1'b0;
              rst_sel_next   = 1'b1;
              state_next     = S_PRESS;
            end
            default: begin
              status_pend_next = ST_INVALID;
              state_next       = S_DONE;
            end
          endcase
        end
      end
      S_PRESS: begin
        // A physical press outranks a tick landing in the same cycle.
        if (phys_any) begin
          status_pend_next = ST_ABORT;
          count_next       = GAP_LOAD;
          state_next       = S_GAP;
        end else if (press_tick) begin
          if (count == 8'd1) begin
            status_pend_next = ST_OK;
            count_next       = GAP_LOAD;
            state_next       = S_GAP;
          end else begin
            count_next = count - 8'd1;
          end
        end
      end
      S_GAP: begin
        if (Strobe125ms) begin
          if (count == 8'd1) begin
            count_next = 8'd0;
            state_next = S_DONE;
          end else begin
            count_next = count - 8'd1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Button outputs follow the next state so the press starts on the edge that accepts it.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      state        <= S_IDLE;
      count        <= 8'd0;
      slow_tick    <= 1'b0;
      rst_sel      <= 1'b0;
      status_pend  <= ST_OK;
      status_q     <= ST_OK;
      VirtPwrBtn_N <= 1'b1;
      VirtRstBtn_N <= 1'b1;
    end else begin
      state        <= state_next;
      count        <= count_next;
      slow_tick    <= slow_tick_next;
      rst_sel      <= rst_sel_next;
      status_pend  <= status_pend_next;
      VirtPwrBtn_N <= !((state_next == S_PRESS) && !rst_sel_next);
      VirtRstBtn_N <= !((state_next == S_PRESS) && rst_sel_next);
      if ((state_next == S_DONE) && (state != S_DONE)) begin
        status_q <= status_pend_next;
      end
    end
  end

  assign cmd.Done   = (state == S_DONE);
  assign cmd.Busy   = (state != S_IDLE);
  assign cmd.Status = status_q;
  assign state_dbg  = state;

endmodule

// File: doc/virtual_button_gen.md
# virtual_button_gen

Generates timed, active-low virtual button presses toward the SIO and reset logic. Software or the BMC requests a short power press, a long (force-off) power press, or a reset press through a valid/ready command port. The block drives the press as the transmitting counterpart of the front-panel button debouncers. It runs in the SlowClock (32,768 Hz) domain, uses the shared 16 ms and 125 ms strobes for timing, and yields to the physical buttons.

## Interface
- SHORT_TICKS, 13: short power press length, in Strobe16ms ticks (≥1)
- LONG_TICKS, 40: long power press length, in Strobe125ms ticks (≥1)
- RST_TICKS, 7: reset press length, in Strobe16ms ticks (≥1)
- GAP_TICKS, 8: post-release lockout, in Strobe125ms ticks (≥1)

- SlowClock  in  1  32,768 Hz clock
- MainReset  in  1  asynchronous, active-low
- Strobe16ms  in  1  single-SlowClock pulse every 16 ms
- Strobe125ms  in  1  single-SlowClock pulse every 125 ms
- CmdValid  in  1  command request
- CmdCode  in  2  01 short power, 10 long power, 11 reset, 00 invalid
- CmdReady  out  1  command can be accepted
- PhysPwrBtn_N  in  1  physical power button, low = pressed, asynchronous
- PhysRstBtn_N  in  1  physical reset button, low = pressed, asynchronous
- VirtPwrBtn_N  out  1  virtual power button, low = pressed
- VirtRstBtn_N  out  1  virtual reset button, low = pressed
- Busy  out  1  command in progress
- Done  out  1  single-cycle completion pulse
- Status  out  2  00 ok, 01 aborted by physical button, 10 invalid code; valid when Done is high, held until the next Done

## Operation
- Both Phys inputs pass through 2-flop synchronizers. PhysAny means either synchronized input is low.
- FSM states are IDLE, PRESS, GAP and DONE.
- CmdReady = (state==IDLE) & !PhysAny.
- Acceptance occurs when CmdValid & CmdReady are high in the same cycle. CmdValid is ignored at all other times, and there is no queueing.
- IDLE, on accept:
  - Code 00: go to DONE with Status=10. No output activity.
  - Code 01: load counter with SHORT_TICKS, select the 16 ms tick, select the power output, go to PRESS.
  - Code 10: load LONG_TICKS, select the 125 ms tick, select the power output, go to PRESS.
  - Code 11: load RST_TICKS, select the 16 ms tick, select the reset output, go to PRESS.
- PRESS:
  - The selected output is driven low (registered).
  - Each selected tick decrements the 8-bit counter.
  - On a tick with count==1, go to GAP with Status=00.
  - If PhysAny is high, go to GAP with Status=01. Abort wins over a coincident tick.
- GAP:
  - Both outputs are high.
  - The counter is loaded with GAP_TICKS on entry and decrements on Strobe125ms.
  - On a tick with count==1, go to DONE.
  - Physical presses in GAP are ignored.
- DONE: Done=1 for one cycle, then IDLE.
- Busy = (state != IDLE).
- Only the selected strobe matters in each state. A coincident Strobe16ms/Strobe125ms has no other effect.
- The counter is 8 bits. Parameters above 255 are illegal.

## Timing
- Reset values:
  - VirtPwrBtn_N=1, VirtRstBtn_N=1
  - Busy=0, Done=0, Status=00
  - state=IDLE, counter=0
  - CmdReady is 1 once the synchronizers have flushed high.
- MainReset asserted mid-press: the outputs release asynchronously and no Done is generated.
- The selected output falls on the first edge after the accept cycle.
- Press width: N tick periods minus the accept-to-first-tick phase, so it lies between (N-1)×T and N×T plus 1 cycle.
- The output rises on the edge after the terminating tick.
- Abort latency: the output rises 3 SlowClock cycles after the physical input falls (2 sync + 1 register).
- Invalid code: Done is asserted on the 2nd cycle after the accept (IDLE→DONE→IDLE).
- The earliest re-accept is the cycle after Done.

## Test plan
- Short press, SHORT_TICKS=13: accept code 01.
  - VirtPwrBtn_N is low 1 cycle after the accept and stays low for 12 to 13 Strobe16ms periods.
  - Then 7 to 8 Strobe125ms gap periods follow, then Done=1 with Status=00. VirtRstBtn_N stays high throughout.
- Long press, LONG_TICKS=40: accept code 10.
  - VirtPwrBtn_N is low for 39 to 40 Strobe125ms periods (≥4.875 s, at least 4 s).
  - Then Done with Status=00.
- Abort: accept code 11, then drive PhysRstBtn_N low after 3 Strobe16ms ticks.
  - VirtRstBtn_N rises exactly 3 cycles later.
  - A full GAP follows, then Done with Status=01.
- Invalid code and busy rejection:
  - CmdCode=00 gives Done on the 2nd cycle after the accept, Status=10, no output edge.
  - CmdValid held during Busy is not accepted, CmdReady=0 for the whole command, and there is no second press.
- Physical priority: hold PhysPwrBtn_N low while in IDLE.
  - CmdReady=0 and CmdValid has no effect.
  - After release, CmdReady=1 within 3 cycles.
- Reset mid-operation: assert MainReset during PRESS of code 10.
  - VirtPwrBtn_N=1 with no clock, Busy=0, and no Done.
  - After deassertion, a new code 01 runs normally.
